// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: owner tags, default widths and
// the legal memory-latency range.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2
  } owner_tag_e;

  localparam int unsigned DEF_ADDR_W      = 15;
  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned MEM_LATENCY_MIN = 1;
  localparam int unsigned MEM_LATENCY_MAX = 3;
  localparam int unsigned STARVE_CNT_W    = 8;

  // Out-of-range latencies are pulled into the supported window.
  function automatic int unsigned clamp_latency(input int unsigned lat);
    if (lat < MEM_LATENCY_MIN) return MEM_LATENCY_MIN;
    if (lat > MEM_LATENCY_MAX) return MEM_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mod_vram_arb_tagpipe.sv
// Owner-tag shift register: one tag enters per cycle and leaves DEPTH cycles later.
// Asynchronous clear drops every tag in flight.
module mod_vram_arb_tagpipe
  import vram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  owner_tag_e in_tag,
  output owner_tag_e out_tag
);

  owner_tag_e stage_q [DEPTH];

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= TAG_NONE;
      end
    end else begin
      stage_q[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/mod_vram_arbiter.sv
// Single-port VRAM arbiter between video scanout and a CPU port, with read-data routing.
// Optional CPU starvation guard enabled by defining VRAM_ARB_STARVE_GUARD_EN.
module mod_vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 7
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_vid_active,
  input  logic              in_vid_req,
  input  logic [ADDR_W-1:0] in_vid_addr,
  output logic              out_vid_gnt,
  output logic              out_vid_rvalid,
  output logic [DATA_W-1:0] out_vid_rdata,
  input  logic              in_cpu_req,
  input  logic              in_cpu_we,
  input  logic [ADDR_W-1:0] in_cpu_addr,
  input  logic [DATA_W-1:0] in_cpu_wdata,
  output logic              out_cpu_gnt,
  output logic              out_cpu_rvalid,
  output logic [DATA_W-1:0] out_cpu_rdata,
  output logic              out_mem_en,
  output logic              out_mem_we,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_wdata,
  input  logic [DATA_W-1:0] in_mem_rdata
);

  // One stage for the command register plus one per memory latency cycle.
  localparam int unsigned PipeDepth = clamp_latency(MEM_LATENCY) + 1;
  localparam logic [STARVE_CNT_W-1:0] StarveMax = STARVE_CNT_W'(STARVE_LIMIT);

  logic       vid_gnt;
  logic       cpu_gnt;
  logic       starve;
  owner_tag_e push_tag;
  owner_tag_e exit_tag;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              vid_rvalid_q;
  logic              cpu_rvalid_q;
  logic [DATA_W-1:0] vid_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  // Grant selection: a starving CPU wins outright; otherwise active display favours
  // video and blanking favours the CPU.
  always_comb begin
    vid_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (starve && in_cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (in_vid_active) begin
      if (in_vid_req) begin
        vid_gnt = 1'b1;
      end else if (in_cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end else begin
      if (in_cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (in_vid_req) begin
        vid_gnt = 1'b1;
      end
    end
  end

  assign out_vid_gnt = vid_gnt;
  assign out_cpu_gnt = cpu_gnt;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  logic [STARVE_CNT_W-1:0] starve_cnt_q;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      starve_cnt_q <= '0;
    end else if (!in_cpu_req || cpu_gnt) begin
      starve_cnt_q <= '0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  assign starve = (starve_cnt_q == StarveMax);
`else
  // Guard compiled out: constant 0 for every legal STARVE_LIMIT.
  assign starve = (StarveMax == '0);
`endif

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= vid_gnt | cpu_gnt;
      mem_we_q <= cpu_gnt & in_cpu_we;
      if (vid_gnt) begin
        mem_addr_q <= in_vid_addr;
      end else if (cpu_gnt) begin
        mem_addr_q  <= in_cpu_addr;
        mem_wdata_q <= in_cpu_wdata;
      end
    end
  end

  assign out_mem_en    = mem_en_q;
  assign out_mem_we    = mem_we_q;
  assign out_mem_addr  = mem_addr_q;
  assign out_mem_wdata = mem_wdata_q;

  always_comb begin
    push_tag = TAG_NONE;
    if (vid_gnt) begin
      push_tag = TAG_VID;
    end else if (cpu_gnt && !in_cpu_we) begin
      push_tag = TAG_CPU;
    end
  end

  mod_vram_arb_tagpipe #(
    .DEPTH(PipeDepth)
  ) u_tagpipe (
    .in_clk  (in_clk),
    .in_rst_n(in_rst_n),
    .in_tag  (push_tag),
    .out_tag (exit_tag)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      vid_rvalid_q <= (exit_tag == TAG_VID);
      cpu_rvalid_q <= (exit_tag == TAG_CPU);
      if (exit_tag == TAG_VID) begin
        vid_rdata_q <= in_mem_rdata;
      end
      if (exit_tag == TAG_CPU) begin
        cpu_rdata_q <= in_mem_rdata;
      end
    end
  end

  assign out_vid_rvalid = vid_rvalid_q;
  assign out_vid_rdata  = vid_rdata_q;
  assign out_cpu_rvalid = cpu_rvalid_q;
  assign out_cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_mod_vram_arbiter.sv
// Bench for mod_vram_arbiter: two instances (memory latency 1 and 3) share stimulus,
// a transaction-level model predicts every output, and directed checks pin the model.
module tb_mod_vram_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 8;
  localparam int unsigned SL = 7;
`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          vid_active;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;

  logic [1:0]    vid_gnt;
  logic [1:0]    cpu_gnt;
  logic [1:0]    vid_rv;
  logic [1:0]    cpu_rv;
  logic [1:0]    m_en;
  logic [1:0]    m_we;
  logic [DW-1:0] vid_rd  [2];
  logic [DW-1:0] cpu_rd  [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] init_val(input int a);
    logic [7:0] lo;
    lo = a[7:0];
    if (a == 16) return 8'hA5;
    return lo * 8'd7 + 8'd3;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %0h want %0h", nm, k, $time, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned L = (g == 0) ? 1 : 3;
    logic [7:0] ram [int];
    logic [7:0] rd_pipe [L];

    // Synchronous RAM with L cycles from command to data.
    always @(posedge clk) begin
      if (m_en[g]) begin
        if (m_we[g]) ram[int'(m_addr[g])] = m_wdata[g];
        else rd_pipe[0] <= ram.exists(int'(m_addr[g])) ? ram[int'(m_addr[g])]
                                                        : init_val(int'(m_addr[g]));
      end
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    mod_vram_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .MEM_LATENCY (L),
      .STARVE_LIMIT(SL)
    ) u_dut (
      .in_clk        (clk),
      .in_rst_n      (rst_n),
      .in_vid_active (vid_active),
      .in_vid_req    (vid_req),
      .in_vid_addr   (vid_addr),
      .out_vid_gnt   (vid_gnt[g]),
      .out_vid_rvalid(vid_rv[g]),
      .out_vid_rdata (vid_rd[g]),
      .in_cpu_req    (cpu_req),
      .in_cpu_we     (cpu_we),
      .in_cpu_addr   (cpu_addr),
      .in_cpu_wdata  (cpu_wdata),
      .out_cpu_gnt   (cpu_gnt[g]),
      .out_cpu_rvalid(cpu_rv[g]),
      .out_cpu_rdata (cpu_rd[g]),
      .out_mem_en    (m_en[g]),
      .out_mem_we    (m_we[g]),
      .out_mem_addr  (m_addr[g]),
      .out_mem_wdata (m_wdata[g]),
      .in_mem_rdata  (rd_pipe[L-1])
    );
  end

  // ---------------- transaction-level model and per-cycle compare ----------------
  typedef struct {
    int         acc;
    bit         vid;
    logic [7:0] data;
  } resp_t;

  resp_t         resp_q [$];
  int            ptr [2];
  logic [7:0]    model_wr [int];
  int            cyc = 0;
  int            starve_m = 0;
  bit            e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [7:0]    e_vrd [2];
  logic [7:0]    e_crd [2];

  always @(negedge clk) begin
    bit    cpu_first, eg_v, eg_c, exp_v, exp_c;
    resp_t r;
    if (!rst_n) begin
      starve_m = 0;
      e_en = 0;
      e_we = 0;
      resp_q.delete();
      for (int k = 0; k < 2; k++) begin
        ptr[k] = 0;
        e_vrd[k] = '0;
        e_crd[k] = '0;
        chk("rst_mem_en", k, m_en[k], 0);
        chk("rst_mem_we", k, m_we[k], 0);
        chk("rst_mem_addr", k, m_addr[k], 0);
        chk("rst_mem_wdata", k, m_wdata[k], 0);
        chk("rst_vid_rvalid", k, vid_rv[k], 0);
        chk("rst_cpu_rvalid", k, cpu_rv[k], 0);
        chk("rst_vid_rdata", k, vid_rd[k], 0);
        chk("rst_cpu_rdata", k, cpu_rd[k], 0);
      end
    end else begin
      cpu_first = (Guard && starve_m == SL) || !vid_active;
      if (cpu_first) begin
        eg_c = cpu_req;
        eg_v = vid_req && !cpu_req;
      end else begin
        eg_v = vid_req;
        eg_c = cpu_req && !vid_req;
      end
      for (int k = 0; k < 2; k++) begin
        chk("vid_gnt", k, vid_gnt[k], eg_v);
        chk("cpu_gnt", k, cpu_gnt[k], eg_c);
        chk("mem_en", k, m_en[k], e_en);
        chk("mem_we", k, m_we[k], e_we);
        if (e_en) chk("mem_addr", k, m_addr[k], e_addr);
        if (e_we) chk("mem_wdata", k, m_wdata[k], e_wdata);
        exp_v = 0;
        exp_c = 0;
        if (ptr[k] < resp_q.size() && resp_q[ptr[k]].acc + lat_of(k) + 2 == cyc) begin
          if (resp_q[ptr[k]].vid) begin
            exp_v = 1;
            e_vrd[k] = resp_q[ptr[k]].data;
          end else begin
            exp_c = 1;
            e_crd[k] = resp_q[ptr[k]].data;
          end
          ptr[k]++;
        end
        chk("vid_rvalid", k, vid_rv[k], exp_v);
        chk("cpu_rvalid", k, cpu_rv[k], exp_c);
        chk("vid_rdata", k, vid_rd[k], e_vrd[k]);
        chk("cpu_rdata", k, cpu_rd[k], e_crd[k]);
      end
      e_en = eg_v || eg_c;
      e_we = 0;
      if (eg_v) begin
        e_addr = vid_addr;
        r.acc = cyc;
        r.vid = 1;
        r.data = model_wr.exists(int'(vid_addr)) ? model_wr[int'(vid_addr)]
                                                 : init_val(int'(vid_addr));
        resp_q.push_back(r);
      end
      if (eg_c) begin
        e_addr = cpu_addr;
        e_we = cpu_we;
        if (cpu_we) begin
          e_wdata = cpu_wdata;
          model_wr[int'(cpu_addr)] = cpu_wdata;
        end else begin
          r.acc = cyc;
          r.vid = 0;
          r.data = model_wr.exists(int'(cpu_addr)) ? model_wr[int'(cpu_addr)]
                                                   : init_val(int'(cpu_addr));
          resp_q.push_back(r);
        end
      end
      if (!cpu_req || eg_c) starve_m = 0;
      else if (starve_m < SL) starve_m++;
    end
    cyc++;
  end

  // ---------------- directed stimulus with hand-computed expectations ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat [2];
    int cnt_v [2];
    int cnt_c [2];
    logic [7:0] rd [2];
    int first, ncg;

    rst_n = 0;
    vid_active = 0;
    vid_req = 0;
    vid_addr = '0;
    cpu_req = 0;
    cpu_we = 0;
    cpu_addr = '0;
    cpu_wdata = '0;
    repeat (3) tick();
    rst_n = 1;
    repeat (2) tick();

    // Single video read of 0x0010 during active display.
    vid_active = 1;
    vid_req = 1;
    vid_addr = 15'h0010;
    @(negedge clk);
    chk("single_vid_gnt", 0, vid_gnt[0], 1);
    chk("single_cpu_gnt", 0, cpu_gnt[0], 0);
    tick();
    vid_req = 0;
    lat = '{-1, -1};
    rd = '{8'h00, 8'h00};
    first = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (vid_rv[k] && lat[k] < 0) begin
          lat[k] = n;
          rd[k] = vid_rd[k];
        end
        first += int'(cpu_rv[k]);
      end
    end
    chk("single_lat", 0, lat[0], 3);
    chk("single_lat", 1, lat[1], 5);
    chk("single_data", 0, rd[0], 8'hA5);
    chk("single_data", 1, rd[1], 8'hA5);
    chk("single_no_cpu_rvalid", 0, first, 0);
    tick();

    // Both requesters held during active display.
    vid_req = 1;
    vid_addr = 15'h0100;
    cpu_req = 1;
    cpu_we = 0;
    cpu_addr = 15'h0200;
    first = -1;
    ncg = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (cpu_gnt[0]) begin
        ncg++;
        if (first < 0) first = n;
      end
      tick();
    end
    chk("starve_first_cpu", 0, first, Guard ? 8 : -1);
    chk("starve_cpu_count", 0, ncg, Guard ? 2 : 0);
    vid_active = 0;
    @(negedge clk);
    chk("blank_cpu_gnt", 0, cpu_gnt[0], 1);
    tick();
    vid_req = 0;
    cpu_req = 0;
    repeat (8) tick();

    // CPU write then read-back on the next cycle.
    cpu_req = 1;
    cpu_we = 1;
    cpu_addr = 15'h1234;
    cpu_wdata = 8'h3C;
    @(negedge clk);
    chk("wr_cpu_gnt", 0, cpu_gnt[0], 1);
    tick();
    cpu_we = 0;
    cpu_wdata = 8'h00;
    @(negedge clk);
    chk("rd_cpu_gnt", 0, cpu_gnt[0], 1);
    tick();
    cpu_req = 0;
    cnt_c = '{0, 0};
    rd = '{8'h00, 8'h00};
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (cpu_rv[k]) begin
          cnt_c[k]++;
          rd[k] = cpu_rd[k];
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk("wr_rd_count", k, cnt_c[k], 1);
      chk("wr_rd_data", k, rd[k], 8'h3C);
    end
    tick();

    // Alternating video/CPU reads every cycle.
    vid_active = 1;
    cnt_v = '{0, 0};
    cnt_c = '{0, 0};
    for (int n = 0; n < 16; n++) begin
      vid_req = (n < 8) && (n % 2 == 0);
      cpu_req = (n < 8) && (n % 2 == 1);
      vid_addr = 15'(32'h300 + n);
      cpu_addr = 15'(32'h300 + n);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        cnt_v[k] += int'(vid_rv[k]);
        cnt_c[k] += int'(cpu_rv[k]);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      chk("ilv_vid_count", k, cnt_v[k], 4);
      chk("ilv_cpu_count", k, cnt_c[k], 4);
    end

    // Reset with a video and a CPU read in flight.
    vid_req = 1;
    vid_addr = 15'h0010;
    tick();
    vid_req = 0;
    cpu_req = 1;
    cpu_addr = 15'h0400;
    tick();
    cpu_req = 0;
    rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_now_mem_en", k, m_en[k], 0);
      chk("rst_now_mem_addr", k, m_addr[k], 0);
      chk("rst_now_vid_rdata", k, vid_rd[k], 0);
      chk("rst_now_cpu_rdata", k, cpu_rd[k], 0);
    end
    tick();
    tick();
    rst_n = 1;
    cnt_v = '{0, 0};
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) cnt_v[k] += int'(vid_rv[k]) + int'(cpu_rv[k]);
    end
    chk("rst_no_stray", 0, cnt_v[0], 0);
    chk("rst_no_stray", 1, cnt_v[1], 0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/mod_vram_arbiter.md
# mod_vram_arbiter

Shares one single-port video RAM between the VGA scanout path (read-only, latency-critical) and a host/CPU port (read/write) in the pixel-clock domain. The arbiter grants at most one access per cycle, registers the memory command, and routes each read's returned data back to the requester that issued it. Video has priority during active display, the CPU has priority during blanking, and an optional starvation guard bounds CPU wait time.

## Interface
Parameters:
- ADDR_W, 15, memory word address width
- DATA_W, 8, memory data width
- MEM_LATENCY, 1, cycles from registered command to valid in_mem_rdata (legal 1..3)
- STARVE_LIMIT, 7, CPU wait cycles before forced CPU grant (legal 1..255)

Ports:
- in_clk  input  1  pixel clock; all logic on rising edge
- in_rst_n  input  1  asynchronous, active-low reset
- in_vid_active  input  1  high during visible display, low during blanking
- in_vid_req  input  1  video read request; held until granted
- in_vid_addr  input  ADDR_W  video read address
- out_vid_gnt  output  1  video request accepted this cycle (combinational)
- out_vid_rvalid  output  1  out_vid_rdata valid, one-cycle pulse
- out_vid_rdata  output  DATA_W  video read data
- in_cpu_req  input  1  CPU request; held with stable addr/we/wdata until granted
- in_cpu_we  input  1  1 = write, 0 = read
- in_cpu_addr  input  ADDR_W  CPU address
- in_cpu_wdata  input  DATA_W  CPU write data
- out_cpu_gnt  output  1  CPU request accepted this cycle (combinational)
- out_cpu_rvalid  output  1  out_cpu_rdata valid, one-cycle pulse
- out_cpu_rdata  output  DATA_W  CPU read data
- out_mem_en  output  1  registered memory access strobe
- out_mem_we  output  1  registered write enable
- out_mem_addr  output  ADDR_W  registered address
- out_mem_wdata  output  DATA_W  registered write data
- in_mem_rdata  input  DATA_W  memory read data

## Operation
- Accept = req && gnt on a port; at most one gnt high per cycle.
- Grant selection, in order: (1) starve flag set and in_cpu_req → CPU; (2) in_vid_active=1 → video if in_vid_req, else CPU if in_cpu_req; (3) in_vid_active=0 → CPU if in_cpu_req, else video if in_vid_req.
- Accepted request registered onto out_mem_* next edge; out_mem_en=0, out_mem_we=0 on idle cycles; addr/wdata hold last value.
- Each accepted read pushes an owner tag (VID/CPU) into a MEM_LATENCY+1 deep tag pipe; writes push NONE. At pipe exit, in_mem_rdata is captured into the owner's rdata register and that owner's rvalid pulses.
- rdata registers hold last value between pulses.
- Starvation counter (8-bit): +1 each cycle in_cpu_req && !out_cpu_gnt, saturating at STARVE_LIMIT; cleared on CPU accept or in_cpu_req=0. Starve flag = (counter == STARVE_LIMIT).
- Reset: all outputs 0, counter 0, tag pipe all NONE; reads in flight at reset assertion never produce rvalid.

## Timing
- Accept at edge N → out_mem_* valid after edge N+1 → in_mem_rdata sampled at edge N+1+MEM_LATENCY → rvalid/rdata high after that edge. Read latency accept-to-rvalid = MEM_LATENCY+2 cycles (3 at default).
- Back-to-back accepts every cycle sustained; responses return in issue order, one per cycle max.
- Write visible to a CPU read accepted on the following cycle (single-port RAM ordering).
- in_vid_active change takes effect in the same cycle's grant decision.

## Configuration
- VRAM_ARB_STARVE_GUARD_EN defined: starvation counter and rule (1) present.
- Undefined: no counter; pure priority by in_vid_active; STARVE_LIMIT ignored; CPU may wait indefinitely during active display.

## Structure
- Package vram_arb_pkg: owner tag enum (TAG_NONE, TAG_VID, TAG_CPU, 2 bits), default ADDR_W/DATA_W constants, MEM_LATENCY legal-range constants.
- Sub-module mod_vram_arb_tagpipe: parameterised-depth owner-tag shift register with async clear; arbiter top holds grant logic, command register, starvation counter, response capture.

## Test plan
- Single video read addr 0x0010, memory model returns 0xA5, active=1 → vid_gnt same cycle, out_vid_rvalid exactly 3 cycles after accept with 0xA5; no cpu_rvalid.
- Both req continuously, active=1, guard enabled, STARVE_LIMIT=7 → CPU granted on 8th cycle of waiting, video resumes next cycle, pattern repeats every 8 cycles.
- Same as previous with macro undefined → CPU never granted while active=1; granted the cycle active drops to 0.
- CPU write 0x3C to 0x1234 then read 0x1234 on next cycle → out_cpu_rdata=0x3C; write produces no rvalid.
- Interleaved vid/cpu reads every cycle with MEM_LATENCY=3 → each rvalid routed to issuer in issue order, latency 5.
- Assert in_rst_n=0 with two reads in flight → all outputs 0 immediately; after release, no stray rvalid.
